// File: rtl/mem_bus_if.sv
// MEM-stage load/store bus interface: alignment check, lane steering,
// req/ack handshake with timeout and pipeline stall generation.
module mem_bus_if #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        stall,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_byteen,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [31:0] rd_orig,
   output logic [1:0]  byte_sel,
   output logic        rd_valid,
   output logic        bus_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic        err_q;
   logic        misal;
   logic        idle;
   logic        accept;
   logic [3:0]  be_n;
   logic [31:0] wd_n;

   always_comb begin
      misal = 1'b0;
      be_n  = 4'b1111;
      wd_n  = req_wdata;
      unique case (req_size)
         2'b00: misal = |req_addr[1:0];
         2'b01: begin
            misal = req_addr[0];
            be_n  = req_addr[1] ? 4'b1100 : 4'b0011;
            wd_n  = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            be_n = 4'b0001 << req_addr[1:0];
            wd_n = {4{req_wdata[7:0]}};
         end
         default: misal = 1'b1;
      endcase
   end

   assign idle     = (state == S_IDLE);
   assign accept   = idle & req_valid & ~flush & ~misal;
   assign exc_adel = idle & req_valid & ~req_we & misal & ~flush;
   assign exc_ades = idle & req_valid & req_we & misal & ~flush;
   assign bus_req  = (state == S_WAIT);
   assign stall    = accept | bus_req;
   assign rd_valid = (state == S_DONE) & ~err_q;
   assign bus_err  = (state == S_DONE) & err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         err_q      <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_byteen <= '0;
         bus_wdata  <= '0;
         rd_orig    <= '0;
         byte_sel   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  bus_we     <= req_we;
                  bus_addr   <= {req_addr[31:2], 2'b00};
                  bus_byteen <= be_n;
                  bus_wdata  <= wd_n;
                  byte_sel   <= req_addr[1:0];
                  cnt        <= '0;
                  err_q      <= 1'b0;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus_ack) begin
                  if (!bus_we) rd_orig <= bus_rdata;
                  err_q <= 1'b0;
                  state <= S_DONE;
               end else if (cnt == TO_LAST) begin
                  // aborted access returns a zero word
                  rd_orig <= '0;
                  err_q   <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_if.sv
// Randomized bench for mem_bus_if against a transaction-level model
// of alignment, lane steering, latency and timeout.
module tb_mem_bus_if;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        stall;
   logic        exc_adel;
   logic        exc_ades;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_byteen;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [31:0] rd_orig;
   logic [1:0]  byte_sel;
   logic        rd_valid;
   logic        bus_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_rd;
   logic [1:0]  exp_bsel;

   mem_bus_if #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .flush(flush),
      .stall(stall), .exc_adel(exc_adel),
      .exc_ades(exc_ades), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .rd_orig(rd_orig), .byte_sel(byte_sel),
      .rd_valid(rd_valid), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_misal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd0) return (a % 4) != 0;
      if (sz == 2'd1) return (a % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 32'd15;
      if (sz == 2'd1) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
      return 32'd1 << (a % 4);
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      if (sz == 2'd2) return (wd & 32'hFF) * 32'h0101_0101;
      return wd;
   endfunction

   // one MEM-stage access; starts and ends just after a clock edge in IDLE
   task automatic access(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic fl, input int dly, input int rst_at,
                         input logic [31:0] rdv);
      bit bad, acc, ack_seen, tmo;
      logic [31:0] word;
      bad = m_misal(sz, a);
      acc = !fl && !bad;
      word = '0;
      ack_seen = 1'b0;
      req_valid = 1'b1;
      req_we = we;
      req_size = sz;
      req_addr = a;
      req_wdata = wd;
      flush = fl;
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      chk("stall_acc", 32'(stall), 32'(acc));
      chk("adel", 32'(exc_adel), 32'(!we && bad && !fl));
      chk("ades", 32'(exc_ades), 32'(we && bad && !fl));
      chk("req_idle", 32'(bus_req), 32'd0);
      tick();
      if (!acc) begin
         req_valid = 1'b0;
         flush = 1'b0;
         bus_ack = 1'b0;
         #1;
         chk("no_req", 32'(bus_req), 32'd0);
         chk("no_stall", 32'(stall), 32'd0);
         return;
      end
      for (int k = 0; k < TO; k++) begin
         chk("wait_req", 32'(bus_req), 32'd1);
         chk("wait_stall", 32'(stall), 32'd1);
         chk("wait_rdv", 32'(rd_valid | bus_err), 32'd0);
         chk("bus_addr", bus_addr, a - (a % 4));
         chk("bus_be", 32'(bus_byteen), m_be(sz, a));
         chk("bus_we", 32'(bus_we), 32'(we));
         if (we) chk("bus_wd", bus_wdata, m_wd(sz, wd));
         flush = 1'($urandom_range(0, 1));
         if (k == rst_at) begin
            reset = 1'b1;
            req_valid = 1'b0;
            flush = 1'b0;
            bus_ack = 1'b0;
            tick();
            reset = 1'b0;
            #1;
            exp_rd = '0;
            exp_bsel = '0;
            chk("rst_req", 32'(bus_req), 32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_pulse", 32'(rd_valid | bus_err), 32'd0);
            chk("rst_rd", rd_orig, exp_rd);
            chk("rst_bsel", 32'(byte_sel), 32'(exp_bsel));
            tick();
            chk("rst_pulse2", 32'(rd_valid | bus_err), 32'd0);
            chk("rst_req2", 32'(bus_req), 32'd0);
            return;
         end
         bus_ack = (k == dly);
         bus_rdata = (k == dly) ? rdv : $urandom;
         word = bus_rdata;
         ack_seen = (k == dly);
         tick();
         if (ack_seen) break;
      end
      flush = 1'b0;
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      tmo = !ack_seen;
      if (tmo) exp_rd = '0;
      else if (!we) exp_rd = word;
      exp_bsel = a[1:0];
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(!tmo));
      chk("bus_err", 32'(bus_err), 32'(tmo));
      chk("rd_orig", rd_orig, exp_rd);
      chk("byte_sel", 32'(byte_sel), 32'(exp_bsel));
      chk("done_req", 32'(bus_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      req_valid = 1'b0;
      tick();
      bus_ack = 1'b0;
      chk("idle_pulse", 32'(rd_valid | bus_err), 32'd0);
      chk("idle_req", 32'(bus_req), 32'd0);
      chk("hold_rd", rd_orig, exp_rd);
   endtask

   initial begin
      int r, dly, ra;
      reset = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'd0;
      req_addr = '0;
      req_wdata = '0;
      flush = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = '0;
      exp_rd = '0;
      exp_bsel = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("r_req", 32'(bus_req), 32'd0);
      chk("r_we", 32'(bus_we), 32'd0);
      chk("r_addr", bus_addr, 32'd0);
      chk("r_be", 32'(bus_byteen), 32'd0);
      chk("r_wd", bus_wdata, 32'd0);
      chk("r_rd", rd_orig, 32'd0);
      chk("r_bsel", 32'(byte_sel), 32'd0);
      chk("r_pulse", 32'(rd_valid | bus_err), 32'd0);
      chk("r_stall", 32'(stall), 32'd0);

      access(1'b0, 2'd0, 32'h3004, 32'h0, 1'b0, 1, -1, 32'hDEADBEEF);
      chk("lw_data", rd_orig, 32'hDEADBEEF);
      access(1'b1, 2'd2, 32'h13, 32'hA5, 1'b0, 0, -1, 32'h1234_5678);
      chk("sb_keep", rd_orig, 32'hDEADBEEF);
      access(1'b0, 2'd1, 32'h1, 32'h0, 1'b0, 0, -1, 32'h0);
      access(1'b1, 2'd0, 32'h2, 32'h0, 1'b0, 0, -1, 32'h0);
      access(1'b0, 2'd3, 32'h0, 32'h0, 1'b0, 0, -1, 32'h0);
      access(1'b1, 2'd3, 32'h4, 32'h0, 1'b0, 0, -1, 32'h0);
      access(1'b0, 2'd0, 32'h40, 32'h0, 1'b0, 100, -1, 32'h0);
      access(1'b0, 2'd0, 32'h80, 32'h0, 1'b1, 0, -1, 32'h0);
      access(1'b0, 2'd0, 32'h100, 32'h0, 1'b0, 10, 2, 32'h0);
      access(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 4, -1, 32'h1111_2222);
      access(1'b0, 2'd1, 32'h6, 32'h0, 1'b0, 4, -1, 32'h3333_4444);
      chk("b2b_bsel", 32'(byte_sel), 32'd2);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         dly = (r == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 5);
         ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 2) : -1;
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom, $urandom,
                ($urandom_range(0, 7) == 0), dly, ra, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- MEM-stage load/store bus interface for the pipelined MIPS core.
- Accepts the MEM-stage memory request and checks alignment. Generates word-aligned bus address, byte enables and replicated store data.
- Runs a req/ack handshake with the system bridge, with a timeout, and stalls the pipeline until the access completes.
- Delivers the raw read word and byte offset to the downstream load data-extension unit.

Parameters:
TIMEOUT, 16, maximum WAIT cycles without bus_ack before the access is aborted with bus_err (legal range 2..255).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  MEM stage holds a load or store
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 word, 01 halfword, 10 byte, 11 reserved
req_addr  input  32  effective byte address
req_wdata  input  32  store data, right-justified
flush  input  1  kill the MEM instruction; honoured only in IDLE
stall  output  1  freeze pipeline stages up to and including MEM
exc_adel  output  1  load address error (combinational)
exc_ades  output  1  store address error (combinational)
bus_req  output  1  bus transaction active
bus_we  output  1  bus write
bus_addr  output  32  word-aligned address {addr[31:2],2'b00}
bus_byteen  output  4  byte-lane enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  bridge completion, sampled on clk
bus_rdata  input  32  read data, valid with bus_ack
rd_orig  output  32  captured read word for the extension unit
byte_sel  output  2  latched req_addr[1:0] for the extension unit
rd_valid  output  1  one-cycle completion pulse
bus_err  output  1  one-cycle pulse: access timed out

Behaviour:
- Reset values:
  - state = IDLE.
  - bus_req, bus_we, rd_valid, bus_err = 0.
  - bus_addr, bus_byteen, bus_wdata, rd_orig = 0.
  - byte_sel = 0; timeout counter = 0.
- Misalignment: size 11, word with addr[1:0]≠0, or half with addr[0]≠0.
  - exc_adel = req_valid & ~req_we & misaligned & ~flush & state==IDLE.
  - exc_ades is the same with req_we.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001 << addr[1:0].
- Store data replication:
  - word: as-is.
  - half: {2{wdata[15:0]}}.
  - byte: {4{wdata[7:0]}}.
- IDLE state:
  - A request is accepted when req_valid & ~flush & ~misaligned.
  - On acceptance: register bus_we/addr/byteen/wdata, latch byte_sel, clear the counter, go to WAIT.
  - stall = 1 combinationally in the acceptance cycle.
  - A misaligned or flushed request gets no bus access, stall = 0 and stays in IDLE.
- WAIT state:
  - bus_req = 1 and stall = 1; bus outputs are held stable.
  - If bus_ack = 1: capture bus_rdata into rd_orig (loads only; stores leave rd_orig unchanged) and go to DONE.
  - If there is no ack and counter == TIMEOUT-1: go to DONE with error flagged and rd_orig = 0.
  - Otherwise the counter increments.
  - flush is ignored in WAIT.
- DONE state:
  - bus_req = 0 and stall = 0.
  - rd_valid = 1 for exactly one cycle; bus_err = 1 instead on timeout (rd_valid = 0).
  - No new request is accepted, because the MEM instruction retires this cycle. Always return to IDLE.
- Latency: accept at cycle N, bus_req high from N+1, ack sampled at cycle M, rd_valid at M+1.
  - Minimum total is 3 cycles (2 stall cycles).
- rd_orig and byte_sel hold their values until the next accepted access.
- bus_ack while in IDLE or DONE is ignored.
- Reset mid-access: next cycle state = IDLE, bus_req = 0, stall = 0, no rd_valid/bus_err pulse.

Test Plan:
- Load word at 0x0000_3004, ack one cycle after bus_req, bus_rdata=0xDEADBEEF:
  - bus_addr=0x3004, byteen=1111.
  - rd_orig=0xDEADBEEF with rd_valid at cycle N+3 (ack at N+2).
  - stall high for N..N+2.
- Store byte 0xA5 to 0x0000_0013:
  - byteen=1000, bus_wdata=0xA5A5A5A5, bus_we=1, bus_addr=0x10.
  - byte_sel=3; rd_orig unchanged.
- Misaligned cases:
  - Load half at 0x0000_0001: exc_adel=1 same cycle, bus_req never rises, stall=0.
  - Store word at 0x0000_0002: exc_ades=1.
  - size=11: exception raised.
- Timeout: no ack with TIMEOUT=16:
  - bus_req high for exactly 16 cycles, then a bus_err pulse, rd_orig=0, stall drops.
- Flush in the acceptance cycle gives no bus_req. Reset asserted in the 3rd WAIT cycle gives bus_req=0 and stall=0 on the next cycle, with no rd_valid.
- Back-to-back loads to 0x0 and 0x6 (half) with ack after 4 wait cycles each:
  - Second bus_req starts only after the first DONE.
  - byteen=1100 and byte_sel=2 on the second access.
